// File: rtl/async_counter_pkg.sv
// ----------------------------------------------------------------------------
// async_counter_pkg
// Shared constants for the 3-bit ripple up/down counter.
//   CNT_W     : counter width (fixed at 3)
//   CNT_RST   : value every stage clears to on reset / power-up
//   MODE_UP   : value of the mode input that selects up counting
//   MODE_DOWN : value of the mode input that selects down counting
// ----------------------------------------------------------------------------
package async_counter_pkg;

    localparam int          CNT_W     = 3;
    localparam logic [2:0]  CNT_RST   = 3'b000;
    localparam logic        MODE_UP   = 1'b0;
    localparam logic        MODE_DOWN = 1'b1;

endpackage : async_counter_pkg

// File: rtl/async_counter_t_ff.sv
// ----------------------------------------------------------------------------
// t_ff
// Rising-edge toggle flip-flop with asynchronous active-low clear. One of
// these forms each stage of the ripple counter.
// Ports:
//   clk   in  : stage clock (system clock or previous stage's selected output)
//   rst_n in  : asynchronous active-low clear
//   t     in  : toggle enable, sampled on the rising edge of clk
//   q     out : stage state
//   qbar  out : exact complement of q, taken from the same flop
// ----------------------------------------------------------------------------
module t_ff
    import async_counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q,
    output logic qbar
);

    // Declaration initialiser gives a defined power-up state so the counter
    // starts from zero even without a reset pulse.
    logic r_q = CNT_RST[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= CNT_RST[0];
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule : t_ff

// File: rtl/async_counter.sv
// ----------------------------------------------------------------------------
// async_counter
// 3-bit asynchronous (ripple) up/down counter built from three T flip-flops.
// Only stage A sees the system clock; stages B and C are clocked by the
// previous stage's true or complement output, chosen by the mode input.
// Ports:
//   clk        in  : system clock, clocks stage A on its rising edge
//   m          in  : mode, 0 = count up, 1 = count down
//   ta/tb/tc   in  : per-stage toggle enables (A = LSB, C = MSB)
//   qa/qb/qc   out : stage states, count value is {qc,qb,qa}
//   qabar..qcbar out : complements of qa..qc
//   rst_n      in  : asynchronous active-low reset, clears all stages
//   count_sync out : (only with ASYNC_COUNTER_SYNC_EN) {qc,qb,qa} registered
//                    on the rising edge of clk, a glitch-free view one cycle
//                    late
// Configuration macro: ASYNC_COUNTER_SYNC_EN
// ----------------------------------------------------------------------------
module async_counter
    import async_counter_pkg::*;
(
    input  logic clk,
    input  logic m,
    input  logic ta,
    input  logic tb,
    input  logic tc,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qabar,
    output logic qbbar,
    output logic qcbar,
    input  logic rst_n
`ifdef ASYNC_COUNTER_SYNC_EN
    ,
    output logic [CNT_W-1:0] count_sync
`endif
);

    logic w_ca;
    logic w_cb;

    // Counting down, a stage must advance when the previous stage rises, so
    // its true output is the clock; counting up it must advance when the
    // previous stage falls, which is a rising edge on the complement. The mux
    // is purely combinational, so flipping m can itself produce a stage clock.
    assign w_ca = (m == MODE_DOWN) ? qa : qabar;
    assign w_cb = (m == MODE_DOWN) ? qb : qbbar;

    t_ff u_stageA (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (ta),
        .q     (qa),
        .qbar  (qabar)
    );

    t_ff u_stageB (
        .clk   (w_ca),
        .rst_n (rst_n),
        .t     (tb),
        .q     (qb),
        .qbar  (qbbar)
    );

    t_ff u_stageC (
        .clk   (w_cb),
        .rst_n (rst_n),
        .t     (tc),
        .q     (qc),
        .qbar  (qcbar)
    );

`ifdef ASYNC_COUNTER_SYNC_EN
    logic [CNT_W-1:0] r_countSync = CNT_RST;

    // Captures the value settled during the previous cycle, before stage A
    // reacts to this edge, so ripple transients never reach this output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_countSync <= CNT_RST;
        end else begin
            r_countSync <= {qc, qb, qa};
        end
    end

    assign count_sync = r_countSync;
`endif

endmodule : async_counter

// File: tb/tb_async_counter.sv
// ----------------------------------------------------------------------------
// tb_async_counter
// Directed test of the ripple counter: reset, up/down counting, mode switch
// between edges, and the per-stage enables. Outputs are sampled on falling
// clock edges, when the ripple has settled.
// ----------------------------------------------------------------------------
module tb_async_counter;

    logic clk;
    logic rst_n;
    logic m;
    logic ta;
    logic tb;
    logic tc;
    logic qa;
    logic qb;
    logic qc;
    logic qabar;
    logic qbbar;
    logic qcbar;
`ifdef ASYNC_COUNTER_SYNC_EN
    logic [2:0] count_sync;
`endif

    int checks   = 0;
    int failures = 0;

    logic [2:0] expVal  = 3'd0;
    logic [2:0] expSync = 3'd0;

    async_counter dut (
        .clk   (clk),
        .m     (m),
        .ta    (ta),
        .tb    (tb),
        .tc    (tc),
        .qa    (qa),
        .qb    (qb),
        .qc    (qc),
        .qabar (qabar),
        .qbbar (qbbar),
        .qcbar (qcbar),
        .rst_n (rst_n)
`ifdef ASYNC_COUNTER_SYNC_EN
        ,
        .count_sync (count_sync)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic mode, input logic tA,
                                 input logic tB, input logic tC);
        m  = mode;
        ta = tA;
        tb = tB;
        tc = tC;
    endtask

    // Compares true and complement outputs against the expected count, and
    // the registered view when that build option is present.
    task automatic checkOutput(input string tag, input logic [2:0] exp);
        logic [5:0] obs;
        logic [5:0] want;
        obs  = {qc, qb, qa, qcbar, qbbar, qabar};
        want = {exp, ~exp};
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("[TB] FAIL %s observed={q,qbar}=%b expected=%b", tag, obs, want);
        end
`ifdef ASYNC_COUNTER_SYNC_EN
        checks++;
        assert (count_sync === expSync) else begin
            failures++;
            $error("[TB] FAIL %s_sync observed=%b expected=%b", tag, count_sync, expSync);
        end
`endif
    endtask

    // One rising clk edge, then sample on the following falling edge.
    task automatic stepEdge(input string tag, input logic [2:0] next);
        expSync = expVal;
        @(posedge clk);
        @(negedge clk);
        expVal = next;
        checkOutput(tag, expVal);
    endtask

    // Asynchronous reset pulse placed between edges; the mode may be changed
    // while the stages are held clear so that mux edges are harmless.
    task automatic resetPulse(input string tag, input logic newMode);
        #2;
        rst_n = 1'b0;
        #1;
        expVal  = 3'd0;
        expSync = 3'd0;
        checkOutput(tag, 3'd0);
        m = newMode;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("reset_initial", 3'd0);
        #2;
        rst_n = 1'b1;

        // Up count: 1..7, 0, 1, 2 then on to 5
        stepEdge("up_1", 3'd1);
        stepEdge("up_2", 3'd2);
        stepEdge("up_3", 3'd3);
        stepEdge("up_4", 3'd4);
        stepEdge("up_5", 3'd5);
        stepEdge("up_6", 3'd6);
        stepEdge("up_7", 3'd7);
        stepEdge("up_wrap0", 3'd0);
        stepEdge("up_wrap1", 3'd1);
        stepEdge("up_wrap2", 3'd2);
        stepEdge("up_to3", 3'd3);
        stepEdge("up_to4", 3'd4);
        stepEdge("up_to5", 3'd5);

        // Reset at value 5 with no clk edge; switch to down mode while held
        resetPulse("reset_mid_count", 1'b1);

        // Down count from 0: 7, 6, 5
        stepEdge("down_7", 3'd7);
        stepEdge("down_6", 3'd6);
        stepEdge("down_5", 3'd5);

        // Mode switch: count up to 6, then raise m between edges -> 2, then 1
        resetPulse("reset_before_switch", 1'b0);
        stepEdge("sw_up1", 3'd1);
        stepEdge("sw_up2", 3'd2);
        stepEdge("sw_up3", 3'd3);
        stepEdge("sw_up4", 3'd4);
        stepEdge("sw_up5", 3'd5);
        stepEdge("sw_up6", 3'd6);
        #1;
        m = 1'b1;
        #1;
        expVal = 3'd2;
        checkOutput("mode_switch", 3'd2);
        stepEdge("after_switch", 3'd1);

        // ta=0 at value 3 freezes the counter
        resetPulse("reset_before_ta", 1'b0);
        stepEdge("ta_up1", 3'd1);
        stepEdge("ta_up2", 3'd2);
        stepEdge("ta_up3", 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        stepEdge("ta_hold1", 3'd3);
        stepEdge("ta_hold2", 3'd3);
        stepEdge("ta_hold3", 3'd3);
        stepEdge("ta_hold4", 3'd3);

        // tb=0 holds qb and with it qc: sequence 1, 0, 1, 0
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        resetPulse("reset_before_tb", 1'b0);
        tb = 1'b0;
        stepEdge("tb_1", 3'd1);
        stepEdge("tb_0", 3'd0);
        stepEdge("tb_1b", 3'd1);
        stepEdge("tb_0b", 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_async_counter
